// File: rtl/iir_multichannel_oscillator_if.sv
// Config write port and tagged sample stream of the
// multi-channel IIR oscillator.
interface iir_multichannel_oscillator_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_chan;
  logic [COEF_W-1:0] cfg_coef;
  logic [DATA_W-1:0] cfg_init;
  logic              cfg_en;

  logic              out_valid;
  logic [CH_W-1:0]   out_chan;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic              frame_done;

  modport master (
    output cfg_valid, cfg_chan, cfg_coef,
    output cfg_init, cfg_en,
    input  cfg_ready,
    input  out_valid, out_chan, out_data,
    input  out_sat, frame_done
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_coef,
    input  cfg_init, cfg_en,
    output cfg_ready,
    output out_valid, out_chan, out_data,
    output out_sat, frame_done
  );
endinterface

// File: rtl/iir_multichannel_oscillator.sv
// Time-multiplexed IIR sinewave oscillator:
// y[n] = K*y[n-1] - y[n-2] per channel, one shared multiplier.
module iir_multichannel_oscillator #(
  parameter int CLK_DIV = 6250,
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16
) (
  input logic clk,
  input logic reset,
  iir_multichannel_oscillator_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int P_W   = COEF_W + DATA_W;
  localparam int T_W   = DATA_W + 2;
  localparam int SH    = COEF_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic [CH_W-1:0]   ch;

  logic signed [COEF_W-1:0] coef_q [NUM_CH];
  logic signed [DATA_W-1:0] s1_q   [NUM_CH];
  logic signed [DATA_W-1:0] s2_q   [NUM_CH];
  logic [NUM_CH-1:0]        en_q;

  logic              rdy_q;
  logic              vld_q;
  logic [CH_W-1:0]   och_q;
  logic [DATA_W-1:0] dat_q;
  logic              sat_q;
  logic              fd_q;

  logic              cfg_fire;
  logic              cfg_hit;

  logic signed [COEF_W-1:0] k_c;
  logic signed [DATA_W-1:0] s1_c;
  logic signed [DATA_W-1:0] s2_c;
  logic signed [P_W-1:0]    k_x;
  logic signed [P_W-1:0]    s1_x;
  logic signed [P_W-1:0]    p_c;
  logic signed [P_W-1:0]    p_sh;
  logic signed [T_W-1:0]    t_c;
  logic signed [DATA_W-1:0] y_c;
  logic                     sat_c;
  logic                     en_c;

  assign tick     = (cnt == CNT_W'(CLK_DIV - 1));
  assign cfg_fire = bus.cfg_valid & rdy_q;
  assign cfg_hit  = cfg_fire &&
    ({{(32-CH_W){1'b0}}, bus.cfg_chan} < 32'(NUM_CH));

  assign bus.cfg_ready  = rdy_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_chan   = och_q;
  assign bus.out_data   = dat_q;
  assign bus.out_sat    = sat_q;
  assign bus.frame_done = fd_q;

  // Free-running sample divider, wraps at CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shared multiply, floor shift back to Q1 and clip.
  always_comb begin
    k_c   = coef_q[ch];
    s1_c  = s1_q[ch];
    s2_c  = s2_q[ch];
    en_c  = en_q[ch];
    k_x   = {{DATA_W{k_c[COEF_W-1]}}, k_c};
    s1_x  = {{COEF_W{s1_c[DATA_W-1]}}, s1_c};
    p_c   = k_x * s1_x;
    p_sh  = p_c >>> SH;
    t_c   = $signed(p_sh[T_W-1:0]) -
            $signed({{2{s2_c[DATA_W-1]}}, s2_c});
    sat_c = !((&t_c[T_W-1:DATA_W-1]) ||
              (~|t_c[T_W-1:DATA_W-1]));
    y_c   = t_c[DATA_W-1:0];
    if (sat_c) begin
      y_c = t_c[T_W-1] ?
        {1'b1, {(DATA_W-1){1'b0}}} :
        {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Channel state: recurrence update in CALC,
  // config writes only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        coef_q[i] <= '0;
        s1_q[i]   <= '0;
        s2_q[i]   <= '0;
      end
      en_q <= '0;
    end else if (state == CALC) begin
      if (en_c) begin
        s2_q[ch] <= s1_c;
        s1_q[ch] <= y_c;
      end
    end else if (cfg_hit) begin
      coef_q[bus.cfg_chan] <= bus.cfg_coef;
      s1_q[bus.cfg_chan]   <= bus.cfg_init;
      s2_q[bus.cfg_chan]   <= '0;
      en_q[bus.cfg_chan]   <= bus.cfg_en;
    end
  end

  // Frame sequencer with registered stream outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ch    <= '0;
      rdy_q <= 1'b1;
      vld_q <= 1'b0;
      och_q <= '0;
      dat_q <= '0;
      sat_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick) begin
            state <= CALC;
            ch    <= '0;
            rdy_q <= 1'b0;
          end
        end
        CALC: begin
          vld_q <= 1'b1;
          och_q <= ch;
          dat_q <= en_c ? y_c : '0;
          sat_q <= en_c & sat_c;
          if (ch == CH_W'(NUM_CH - 1)) begin
            state <= DONE;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          rdy_q <= 1'b1;
          fd_q  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iir_multichannel_oscillator.sv
// Scoreboard bench for the multi-channel IIR oscillator.
// Directed vectors, expected samples worked out by hand.
module tb_iir_multichannel_oscillator;
  localparam int CLK_DIV = 8;
  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 16;
  localparam int COEF_W  = 16;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iir_multichannel_oscillator_if #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .COEF_W(COEF_W)
  ) bus ();

  iir_multichannel_oscillator #(
    .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH),
    .DATA_W(DATA_W), .COEF_W(COEF_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string name,
                       input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input int c, input int d, input bit s);
    exp_t e;
    e.ch   = 2'(c);
    e.data = 16'(d);
    e.sat  = s;
    sb.push_back(e);
  endtask

  task automatic push_frame(input int d0, input bit s0,
                            input int d1, input bit s1,
                            input int d2, input bit s2,
                            input int d3, input bit s3);
    push(0, d0, s0);
    push(1, d1, s1);
    push(2, d2, s2);
    push(3, d3, s3);
  endtask

  task automatic set_cfg(input int c, input int k,
                         input int i, input bit e);
    bus.cfg_chan = 2'(c);
    bus.cfg_coef = 16'(k);
    bus.cfg_init = 16'(i);
    bus.cfg_en   = e;
  endtask

  task automatic wait_fd(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        seen = 1;
        break;
      end
    end
    check(name, int'(seen), 1);
  endtask

  task automatic wait_ch0(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_chan == 2'd0) begin
        seen = 1;
        break;
      end
    end
    check(name, int'(seen), 1);
  endtask

  // Monitor: pops one expectation per strobe and
  // checks frame_done follows the last channel.
  initial begin : mon
    exp_t e;
    bit last_seen;
    last_seen = 0;
    forever begin
      @(negedge clk);
      if (bus.frame_done) begin
        checks++;
        if (!last_seen) begin
          errors++;
          $display("FAIL frame_done_pos got=1 want=after_ch%0d",
                   NUM_CH - 1);
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out ch=%0d data=%0d",
                   bus.out_chan, $signed(bus.out_data));
        end else begin
          e = sb.pop_front();
          if (bus.out_chan !== e.ch ||
              bus.out_data !== e.data ||
              bus.out_sat !== e.sat) begin
            errors++;
            $display("FAIL out got ch=%0d d=%0d s=%0d want ch=%0d d=%0d s=%0d",
                     bus.out_chan, $signed(bus.out_data),
                     bus.out_sat, e.ch, $signed(e.data), e.sat);
          end
        end
      end
      last_seen = bus.out_valid &&
                  (bus.out_chan == 2'(NUM_CH - 1));
    end
  end

  initial begin : stim
    int lat;
    int k;
    int n;
    int prev;
    int nfd;
    bus.cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0);

    // reset values
    #1 reset = 1'b1;
    #1;
    check("rst_cfg_ready", int'(bus.cfg_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // tone, +sat, disabled, -sat in consecutive cycles
    set_cfg(0, 23170, 11585, 1);
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    set_cfg(1, 32767, 32767, 1);
    @(negedge clk);
    set_cfg(2, 23170, 11585, 0);
    @(negedge clk);
    set_cfg(3, -32768, 32767, 1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    push_frame(16383, 0, 32767, 1, 0, 0, -32768, 1);
    push_frame(11583, 0, 32765, 0, 0, 0, 32767, 1);
    push_frame(-3, 0, 32761, 0, 0, 0, -32766, 0);
    push_frame(-11588, 0, 32755, 0, 0, 0, 32765, 0);
    push_frame(-16385, 0, 32747, 0, 0, 0, -32764, 0);
    repeat (5) wait_fd("fd_phase1");

    // reset in the middle of a frame
    push(0, -11584, 0);
    wait_ch0("ch0_frame6");
    #2;
    check("calc_cfg_ready", int'(bus.cfg_ready), 0);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_frame_done", int'(bus.frame_done), 0);
    check("midrst_cfg_ready", int'(bus.cfg_ready), 1);
    check("midrst_out_data", int'(bus.out_data), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // write in the tick cycle, first-output latency
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 7) begin
        check("ready_at_tick", int'(bus.cfg_ready), 1);
        set_cfg(0, 23170, 11585, 1);
        bus.cfg_valid = 1'b1;
        push_frame(16383, 0, 0, 0, 0, 0, 0, 0);
        push_frame(11583, 0, 0, 0, 0, 0, 0, 0);
      end
      if (i == 8) bus.cfg_valid = 1'b0;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check("first_out_latency", lat, 9);

    // write held across CALC/DONE
    wait_fd("fd_frameA");
    wait_ch0("ch0_frameB");
    set_cfg(2, 23170, 11585, 1);
    bus.cfg_valid = 1'b1;
    check("stall_ready_low", int'(bus.cfg_ready), 0);
    push_frame(-3, 0, 0, 0, 16383, 0, 0, 0);
    push_frame(-11588, 0, 0, 0, 11583, 0, 0, 0);
    k = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.cfg_ready) begin
        k = i;
        break;
      end
    end
    check("stall_cycles", k, 4);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    wait_fd("fd_frameC");
    wait_fd("fd_frameD");
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // divider wrap over 100 tick intervals
    for (int f = 0; f < 101; f++) begin
      push_frame(0, 0, 0, 0, 0, 0, 0, 0);
    end
    n = 0;
    prev = -1;
    nfd = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      n++;
      if (bus.frame_done) begin
        if (prev < 0) check("first_fd", n, 13);
        else check("fd_interval", n - prev, CLK_DIV);
        prev = n;
        nfd++;
        if (nfd == 101) break;
      end
    end
    check("fd_count", nfd, 101);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
